vector_register_file: RTL and testbench
=======================================

Name: vector_register_file

Overview:
- Per-thread scalar and vector register file for the compute core; the successor of the fixed 8-bit, 4-lane thread register block.
- Register count, lane count and data width are parametrised.
- Adds three features: vector writeback from memory, constant or scalar broadcast, and per-lane write masking.
- Adds a multi-cycle vector clear sweep with a busy flag.
- Sits between the decoder/scheduler and the scalar/vector ALU and LSU of each thread.

Parameters:
- DATA_BITS, 8, width of one scalar register and of one vector lane
- LANES, 4, number of lanes per vector register
- NUM_REGS, 16, scalar register count; the top 3 indices are read-only
- NUM_VREGS, 16, vector register count; all are writable
- ADDR_BITS, 4, address width; must satisfy 2^ADDR_BITS >= max(NUM_REGS, NUM_VREGS)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  thread active; gates all REQUEST/UPDATE activity
- core_id, engine_id, task_id  in  8 each  kernel identifiers, zero-extended or truncated to DATA_BITS
- core_state  in  3  scheduler state; REQUEST=3'b011, UPDATE=3'b110
- decoded_rd_address, decoded_rs_address, decoded_rt_address  in  ADDR_BITS each  register indices
- decoded_reg_write_enable  in  1  write rd in UPDATE
- decoded_reg_input_mux  in  2  writeback source: 00 ARITH, 01 MEMORY, 10 CONSTANT, 11 BROADCAST
- decoded_immediate  in  DATA_BITS  constant operand
- decoded_vector_mux  in  1  1 selects the vector file, 0 the scalar file
- decoded_lane_mask  in  LANES  per-lane write enable for vector writes
- clear_req  in  1  one-cycle pulse that starts the vector clear sweep
- alu_out, lsu_out  in  DATA_BITS each  scalar results
- v_alu_out, v_lsu_out  in  LANES*DATA_BITS each  vector results; lane i occupies bits [i*DATA_BITS +: DATA_BITS]
- rs, rt  out  DATA_BITS each  registered scalar operands
- v_rs, v_rt  out  LANES*DATA_BITS each  registered vector operands
- read_valid  out  1  one-cycle pulse the cycle after an operand capture
- clear_busy  out  1  high while the clear sweep runs

Behaviour:
- Reset (reset_n low, asynchronous):
  - rs, rt, v_rs, v_rt, read_valid and clear_busy all go to 0.
  - All scalar free registers and all vector registers go to 0.
  - The sweep counter goes to 0.
- Read-only scalar registers:
  - Indices NUM_REGS-3, NUM_REGS-2 and NUM_REGS-1 are not storage.
  - Reading them returns the live core_id, engine_id and task_id respectively.
  - Writes to them are silently ignored.
- Operand read (enable=1, core_state=REQUEST):
  - Capture happens on the next clock edge; read_valid is 1 in the following cycle only.
  - vector_mux=0: rs/rt are loaded; v_rs/v_rt hold their values.
  - vector_mux=1: v_rs/v_rt are loaded; rs/rt hold their values.
  - Out-of-range address (>= NUM_REGS for scalar, >= NUM_VREGS for vector) reads as 0.
  - Reads see register contents from before the same-edge write; there is no bypass.
- Scalar write (enable=1, core_state=UPDATE, write_enable=1, vector_mux=0, rd < NUM_REGS-3):
  - ARITH writes alu_out.
  - MEMORY writes lsu_out.
  - CONSTANT writes decoded_immediate.
  - BROADCAST is a no-op for scalar writes.
- Vector write (same conditions with vector_mux=1, rd < NUM_VREGS):
  - Source per lane: ARITH takes v_alu_out lane i; MEMORY takes v_lsu_out lane i; CONSTANT takes decoded_immediate in every lane.
  - BROADCAST takes the current scalar register[rs_address] (the read-only mapping applies) in every lane.
  - Lane i is written only if decoded_lane_mask[i]=1; masked lanes keep their value.
  - A mask of all zeros is a no-op.
- Clear sweep FSM, with states IDLE and SWEEP:
  - IDLE -> SWEEP on clear_req=1. Sweep counter cnt=0, clear_busy=1 from the next cycle.
  - In SWEEP, each cycle zeroes vreg[cnt] and increments cnt.
  - At cnt=NUM_VREGS-1 the FSM zeroes that register and returns to IDLE; clear_busy drops in the next cycle.
  - clear_busy is high for exactly NUM_VREGS cycles.
  - clear_req during SWEEP is ignored.
  - The sweep runs regardless of enable.
  - During SWEEP, vector writes are dropped and vector reads return 0.
  - Scalar reads and writes are unaffected by the sweep.
- Reset asserted mid-sweep immediately returns the FSM to IDLE with every register cleared.

Decomposition:
- Shared package (core_pkg) holds:
  - state encodings STATE_REQUEST and STATE_UPDATE;
  - writeback mux codes ARITH, MEMORY, CONSTANT and BROADCAST;
  - the read-only register count (3).
- One sub-module, vreg_lane_writer:
  - computes the masked next value of one vector register from its source and mask;
  - is instantiated once per write port.

Test Plan:
- Reset, then read scalar r13/r14/r15 with core_id=5, engine_id=2, task_id=9 -> rs/rt give 5/2/9, and read_valid pulses once.
- Scalar CONSTANT write 0x3C to r4, then read r4 -> rs=0x3C. Writing r14 leaves the read of r14 equal to engine_id.
- Vector write: ARITH of v_alu_out=0x44332211 to v2 with mask 4'b0101, then read v2 -> v_rs=0x00330011.
- Vector MEMORY write of v_lsu_out=0xA1B2C3D4 to v7 with mask 4'b1111 -> v_rt=0xA1B2C3D4. BROADCAST from scalar r4=0x3C to v3 -> 0x3C3C3C3C.
- Fill v0..v15 nonzero, pulse clear_req:
  - clear_busy is high for exactly 16 cycles;
  - a vector write issued mid-sweep is dropped;
  - afterwards every vreg reads 0.
- Pull reset_n low asynchronously mid-sweep (cnt=6) -> clear_busy=0 immediately; all outputs and registers read 0 after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the per-thread register file: scheduler states,
// writeback source codes, read-only register count and clear-sweep FSM states.
package core_pkg;

  localparam logic [2:0] STATE_REQUEST = 3'b011;
  localparam logic [2:0] STATE_UPDATE  = 3'b110;

  typedef enum logic [1:0] {
    ARITH     = 2'b00,
    MEMORY    = 2'b01,
    CONSTANT  = 2'b10,
    BROADCAST = 2'b11
  } wb_mux_e;

  // Top scalar indices map to core_id, engine_id, task_id.
  localparam int NUM_RO_REGS = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/vreg_lane_writer.sv
// Merges a source vector into an old vector register value lane by lane under a mask.
// Purely combinational, no backpressure; a zero mask returns the old value unchanged.
module vreg_lane_writer #(
  parameter int DATA_BITS = 8,
  parameter int LANES     = 4
) (
  input  logic [LANES*DATA_BITS-1:0] old_dat,
  input  logic [LANES*DATA_BITS-1:0] src_dat,
  input  logic [LANES-1:0]           lane_mask,
  output logic [LANES*DATA_BITS-1:0] new_dat
);

  always_comb begin
    new_dat = old_dat;
    for (int i = 0; i < LANES; i++) begin
      if (lane_mask[i]) begin
        new_dat[i*DATA_BITS +: DATA_BITS] = src_dat[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

endmodule

// File: rtl/vector_register_file.sv
// Per-thread scalar/vector register file with masked vector writeback and a clear sweep.
// Operands are registered one cycle after REQUEST; the sweep takes NUM_VREGS cycles and never stalls.
module vector_register_file
  import core_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int LANES     = 4,
  parameter int NUM_REGS  = 16,
  parameter int NUM_VREGS = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [7:0]                 core_id,
  input  logic [7:0]                 engine_id,
  input  logic [7:0]                 task_id,
  input  logic [2:0]                 core_state,
  input  logic [ADDR_BITS-1:0]       decoded_rd_address,
  input  logic [ADDR_BITS-1:0]       decoded_rs_address,
  input  logic [ADDR_BITS-1:0]       decoded_rt_address,
  input  logic                       decoded_reg_write_enable,
  input  logic [1:0]                 decoded_reg_input_mux,
  input  logic [DATA_BITS-1:0]       decoded_immediate,
  input  logic                       decoded_vector_mux,
  input  logic [LANES-1:0]           decoded_lane_mask,
  input  logic                       clear_req,
  input  logic [DATA_BITS-1:0]       alu_out,
  input  logic [DATA_BITS-1:0]       lsu_out,
  input  logic [LANES*DATA_BITS-1:0] v_alu_out,
  input  logic [LANES*DATA_BITS-1:0] v_lsu_out,
  output logic [DATA_BITS-1:0]       rs,
  output logic [DATA_BITS-1:0]       rt,
  output logic [LANES*DATA_BITS-1:0] v_rs,
  output logic [LANES*DATA_BITS-1:0] v_rt,
  output logic                       read_valid,
  output logic                       clear_busy
);

  localparam int NUM_FREE = NUM_REGS - NUM_RO_REGS;
  localparam int VBITS    = LANES * DATA_BITS;
  localparam int IDW      = (DATA_BITS < 8) ? DATA_BITS : 8;

  logic [DATA_BITS-1:0] regs_q  [NUM_FREE];
  logic [DATA_BITS-1:0] regs_d  [NUM_FREE];
  logic [VBITS-1:0]     vregs_q [NUM_VREGS];
  logic [VBITS-1:0]     vregs_d [NUM_VREGS];

  sweep_state_e         state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;

  logic [DATA_BITS-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [VBITS-1:0]     v_rs_q, v_rs_d, v_rt_q, v_rt_d;
  logic                 read_valid_q, read_valid_d;

  int rd_i, rs_i, rt_i, cnt_i;
  assign rd_i  = int'(decoded_rd_address);
  assign rs_i  = int'(decoded_rs_address);
  assign rt_i  = int'(decoded_rt_address);
  assign cnt_i = int'(cnt_q);

  logic sweeping;
  assign sweeping = (state_q == SWEEP);

  // Architectural scalar view: free storage below, live kernel identifiers on top.
  logic [DATA_BITS-1:0] ro_val [NUM_RO_REGS];
  logic [DATA_BITS-1:0] sview  [NUM_REGS];
  assign ro_val[0] = DATA_BITS'(core_id[IDW-1:0]);
  assign ro_val[1] = DATA_BITS'(engine_id[IDW-1:0]);
  assign ro_val[2] = DATA_BITS'(task_id[IDW-1:0]);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_sview
    if (g < NUM_FREE) begin : g_free
      assign sview[g] = regs_q[g];
    end else begin : g_ro
      assign sview[g] = ro_val[g-NUM_FREE];
    end
  end

  // Out-of-range indices match nothing and therefore read as zero.
  logic [DATA_BITS-1:0] rs_rd, rt_rd;
  logic [VBITS-1:0]     v_rs_rd, v_rt_rd, v_old;
  always_comb begin
    rs_rd   = '0;
    rt_rd   = '0;
    v_rs_rd = '0;
    v_rt_rd = '0;
    v_old   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == rs_i) rs_rd = sview[i];
      if (i == rt_i) rt_rd = sview[i];
    end
    for (int i = 0; i < NUM_VREGS; i++) begin
      if (i == rs_i && !sweeping) v_rs_rd = vregs_q[i];
      if (i == rt_i && !sweeping) v_rt_rd = vregs_q[i];
      if (i == rd_i)              v_old   = vregs_q[i];
    end
  end

  logic [DATA_BITS-1:0] wb_scalar;
  logic [VBITS-1:0]     v_src, v_new;
  always_comb begin
    wb_scalar = '0;
    v_src     = '0;
    case (wb_mux_e'(decoded_reg_input_mux))
      ARITH:     begin wb_scalar = alu_out;           v_src = v_alu_out;                    end
      MEMORY:    begin wb_scalar = lsu_out;           v_src = v_lsu_out;                    end
      CONSTANT:  begin wb_scalar = decoded_immediate; v_src = {LANES{decoded_immediate}};   end
      BROADCAST: begin wb_scalar = '0;                v_src = {LANES{rs_rd}};               end
      default:   begin wb_scalar = '0;                v_src = '0;                           end
    endcase
  end

  vreg_lane_writer #(
    .DATA_BITS (DATA_BITS),
    .LANES     (LANES)
  ) u_vwr (
    .old_dat   (v_old),
    .src_dat   (v_src),
    .lane_mask (decoded_lane_mask),
    .new_dat   (v_new)
  );

  logic wr_base, scalar_we, vector_we, capture;
  assign wr_base   = enable && (core_state == STATE_UPDATE) && decoded_reg_write_enable;
  assign scalar_we = wr_base && !decoded_vector_mux && (rd_i < NUM_FREE)
                     && (wb_mux_e'(decoded_reg_input_mux) != BROADCAST);
  assign vector_we = wr_base && decoded_vector_mux && (rd_i < NUM_VREGS) && !sweeping;
  assign capture   = enable && (core_state == STATE_REQUEST);

  always_comb begin
    regs_d  = regs_q;
    vregs_d = vregs_q;
    for (int i = 0; i < NUM_FREE; i++) begin
      if (scalar_we && i == rd_i) regs_d[i] = wb_scalar;
    end
    for (int i = 0; i < NUM_VREGS; i++) begin
      if (vector_we && i == rd_i) vregs_d[i] = v_new;
      if (sweeping && i == cnt_i) vregs_d[i] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_i == NUM_VREGS - 1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rs_d         = (capture && !decoded_vector_mux) ? rs_rd   : rs_q;
    rt_d         = (capture && !decoded_vector_mux) ? rt_rd   : rt_q;
    v_rs_d       = (capture &&  decoded_vector_mux) ? v_rs_rd : v_rs_q;
    v_rt_d       = (capture &&  decoded_vector_mux) ? v_rt_rd : v_rt_q;
    read_valid_d = capture;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_FREE; i++)  regs_q[i]  <= '0;
      for (int i = 0; i < NUM_VREGS; i++) vregs_q[i] <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      v_rs_q       <= '0;
      v_rt_q       <= '0;
      read_valid_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      vregs_q      <= vregs_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      v_rs_q       <= v_rs_d;
      v_rt_q       <= v_rt_d;
      read_valid_q <= read_valid_d;
    end
  end

  assign rs         = rs_q;
  assign rt         = rt_q;
  assign v_rs       = v_rs_q;
  assign v_rt       = v_rt_q;
  assign read_valid = read_valid_q;
  assign clear_busy = sweeping;

endmodule

// File: tb/tb_vector_register_file.sv
// Directed bench for vector_register_file at default parameters (8-bit data, 4 lanes, 16+16 registers).
module tb_vector_register_file;

  localparam logic [2:0] S_REQ = 3'b011;
  localparam logic [2:0] S_UPD = 3'b110;
  localparam logic [1:0] M_ARITH = 2'b00, M_MEM = 2'b01, M_CONST = 2'b10, M_BCAST = 2'b11;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b1;
  logic [7:0]  core_id = 8'd5, engine_id = 8'd2, task_id = 8'd9;
  logic [2:0]  core_state = 3'b000;
  logic [3:0]  decoded_rd_address = '0, decoded_rs_address = '0, decoded_rt_address = '0;
  logic        decoded_reg_write_enable = 1'b0;
  logic [1:0]  decoded_reg_input_mux = '0;
  logic [7:0]  decoded_immediate = '0;
  logic        decoded_vector_mux = 1'b0;
  logic [3:0]  decoded_lane_mask = '0;
  logic        clear_req = 1'b0;
  logic [7:0]  alu_out = '0, lsu_out = '0;
  logic [31:0] v_alu_out = '0, v_lsu_out = '0;
  logic [7:0]  rs, rt;
  logic [31:0] v_rs, v_rt;
  logic        read_valid, clear_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_register_file dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .core_id(core_id), .engine_id(engine_id), .task_id(task_id),
    .core_state(core_state),
    .decoded_rd_address(decoded_rd_address), .decoded_rs_address(decoded_rs_address),
    .decoded_rt_address(decoded_rt_address),
    .decoded_reg_write_enable(decoded_reg_write_enable),
    .decoded_reg_input_mux(decoded_reg_input_mux),
    .decoded_immediate(decoded_immediate), .decoded_vector_mux(decoded_vector_mux),
    .decoded_lane_mask(decoded_lane_mask), .clear_req(clear_req),
    .alu_out(alu_out), .lsu_out(lsu_out), .v_alu_out(v_alu_out), .v_lsu_out(v_lsu_out),
    .rs(rs), .rt(rt), .v_rs(v_rs), .v_rt(v_rt),
    .read_valid(read_valid), .clear_busy(clear_busy)
  );

  // Stimulus drivers: called #1 after a rising edge, they leave inputs idle on return.
  task automatic set_idle();
    core_state = 3'b000;
    decoded_reg_write_enable = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic drive_upd(input logic vm, input logic [3:0] rd, input logic [1:0] mux,
                           input logic [3:0] mask, input logic [3:0] rsa);
    core_state = S_UPD;
    decoded_vector_mux = vm;
    decoded_rd_address = rd;
    decoded_reg_input_mux = mux;
    decoded_lane_mask = mask;
    decoded_rs_address = rsa;
    decoded_reg_write_enable = 1'b1;
  endtask

  task automatic drive_req(input logic vm, input logic [3:0] rsa, input logic [3:0] rta);
    core_state = S_REQ;
    decoded_vector_mux = vm;
    decoded_rs_address = rsa;
    decoded_rt_address = rta;
  endtask

  task automatic upd(input logic vm, input logic [3:0] rd, input logic [1:0] mux,
                     input logic [3:0] mask, input logic [3:0] rsa);
    drive_upd(vm, rd, mux, mask, rsa);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic req(input logic vm, input logic [3:0] rsa, input logic [3:0] rta);
    drive_req(vm, rsa, rta);
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({rs, rt} !== 16'h0) begin n_err++; $display("FAIL reset_scalar_out: got %h expected 0000", {rs, rt}); end
    n_cmp++; if ({v_rs, v_rt} !== 64'h0) begin n_err++; $display("FAIL reset_vector_out: got %h expected 0", {v_rs, v_rt}); end
    n_cmp++; if ({read_valid, clear_busy} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {read_valid, clear_busy}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ro_regs();
    req(1'b0, 4'd13, 4'd14);
    n_cmp++; if ({rs, rt} !== {8'd5, 8'd2}) begin n_err++; $display("FAIL ro_core_engine: got %h expected 0502", {rs, rt}); end
    n_cmp++; if (read_valid !== 1'b1) begin n_err++; $display("FAIL read_valid_high: got %b expected 1", read_valid); end
    @(posedge clk); #1;
    n_cmp++; if (read_valid !== 1'b0) begin n_err++; $display("FAIL read_valid_pulse: got %b expected 0", read_valid); end
    req(1'b0, 4'd15, 4'd0);
    n_cmp++; if ({rs, rt} !== {8'd9, 8'd0}) begin n_err++; $display("FAIL ro_task: got %h expected 0900", {rs, rt}); end
  endtask

  task automatic test_scalar_write();
    decoded_immediate = 8'h3C; upd(1'b0, 4'd4, M_CONST, 4'h0, 4'd0);
    decoded_immediate = 8'h77; upd(1'b0, 4'd14, M_CONST, 4'h0, 4'd0);
    alu_out = 8'h5A;           upd(1'b0, 4'd5, M_ARITH, 4'h0, 4'd0);
    lsu_out = 8'hC3;           upd(1'b0, 4'd6, M_MEM, 4'h0, 4'd0);
    alu_out = 8'hEE;           upd(1'b0, 4'd7, M_BCAST, 4'h0, 4'd4);
    decoded_immediate = 8'h81; enable = 1'b0;
    upd(1'b0, 4'd8, M_CONST, 4'h0, 4'd0);
    enable = 1'b1;
    req(1'b0, 4'd4, 4'd14);
    n_cmp++; if ({rs, rt} !== {8'h3C, 8'h02}) begin n_err++; $display("FAIL scalar_const_ro_ignore: got %h expected 3c02", {rs, rt}); end
    req(1'b0, 4'd7, 4'd8);
    n_cmp++; if ({rs, rt} !== 16'h0000) begin n_err++; $display("FAIL scalar_bcast_disabled_noop: got %h expected 0000", {rs, rt}); end
    req(1'b0, 4'd5, 4'd6);
    n_cmp++; if ({rs, rt} !== {8'h5A, 8'hC3}) begin n_err++; $display("FAIL scalar_arith_mem: got %h expected 5ac3", {rs, rt}); end
  endtask

  task automatic test_vector_write();
    v_alu_out = 32'h44332211; upd(1'b1, 4'd2, M_ARITH, 4'b0101, 4'd0);
    req(1'b1, 4'd2, 4'd0);
    n_cmp++; if (v_rs !== 32'h00330011) begin n_err++; $display("FAIL vec_mask_0101: got %h expected 00330011", v_rs); end
    n_cmp++; if (rs !== 8'h5A) begin n_err++; $display("FAIL scalar_hold_on_vread: got %h expected 5a", rs); end
    v_alu_out = 32'hDDCCBBAA; upd(1'b1, 4'd2, M_ARITH, 4'b1010, 4'd0);
    v_alu_out = 32'hFFFFFFFF; upd(1'b1, 4'd2, M_ARITH, 4'b0000, 4'd0);
    v_lsu_out = 32'hA1B2C3D4; upd(1'b1, 4'd7, M_MEM, 4'b1111, 4'd0);
    upd(1'b1, 4'd3, M_BCAST, 4'b1111, 4'd4);
    upd(1'b1, 4'd9, M_BCAST, 4'b1111, 4'd13);
    decoded_immediate = 8'h5E; upd(1'b1, 4'd10, M_CONST, 4'b0110, 4'd0);
    req(1'b1, 4'd2, 4'd7);
    n_cmp++; if (v_rs !== 32'hDD33BB11) begin n_err++; $display("FAIL vec_mask_merge_zero_mask: got %h expected dd33bb11", v_rs); end
    n_cmp++; if (v_rt !== 32'hA1B2C3D4) begin n_err++; $display("FAIL vec_memory: got %h expected a1b2c3d4", v_rt); end
    req(1'b1, 4'd3, 4'd9);
    n_cmp++; if (v_rs !== 32'h3C3C3C3C) begin n_err++; $display("FAIL vec_bcast_r4: got %h expected 3c3c3c3c", v_rs); end
    n_cmp++; if (v_rt !== 32'h05050505) begin n_err++; $display("FAIL vec_bcast_core_id: got %h expected 05050505", v_rt); end
    req(1'b1, 4'd10, 4'd11);
    n_cmp++; if ({v_rs, v_rt} !== {32'h005E5E00, 32'h0}) begin n_err++; $display("FAIL vec_const_mask: got %h expected 005e5e0000000000", {v_rs, v_rt}); end
  endtask

  task automatic test_clear_sweep();
    int cycles;
    for (int i = 0; i < 16; i++) begin
      decoded_immediate = 8'(i + 1);
      upd(1'b1, 4'(i), M_CONST, 4'b1111, 4'd0);
    end
    req(1'b1, 4'd0, 4'd15);
    n_cmp++; if ({v_rs, v_rt} !== {32'h01010101, 32'h10101010}) begin n_err++; $display("FAIL fill: got %h expected 0101010110101010", {v_rs, v_rt}); end
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    cycles = 0;
    while (clear_busy === 1'b1 && cycles < 40) begin
      cycles++;
      set_idle();
      case (cycles)
        3: begin decoded_immediate = 8'hEE; drive_upd(1'b1, 4'd0, M_CONST, 4'b1111, 4'd0); end
        4: clear_req = 1'b1;
        5: drive_req(1'b1, 4'd15, 4'd14);
        6: begin decoded_immediate = 8'h99; drive_upd(1'b0, 4'd9, M_CONST, 4'b0000, 4'd0); end
        7: drive_req(1'b0, 4'd9, 4'd4);
        default: ;
      endcase
      @(posedge clk); #1;
    end
    set_idle();
    n_cmp++; if (cycles !== 16) begin n_err++; $display("FAIL busy_cycles: got %0d expected 16", cycles); end
    n_cmp++; if ({v_rs, v_rt} !== 64'h0) begin n_err++; $display("FAIL vread_during_sweep: got %h expected 0", {v_rs, v_rt}); end
    n_cmp++; if ({rs, rt} !== {8'h99, 8'h3C}) begin n_err++; $display("FAIL scalar_during_sweep: got %h expected 993c", {rs, rt}); end
    for (int i = 0; i < 16; i += 2) begin
      req(1'b1, 4'(i), 4'(i + 1));
      n_cmp++; if ({v_rs, v_rt} !== 64'h0) begin n_err++; $display("FAIL cleared_v%0d_v%0d: got %h expected 0", i, i + 1, {v_rs, v_rt}); end
    end
    n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL busy_after_sweep: got %b expected 0", clear_busy); end
  endtask

  task automatic test_reset_mid_sweep();
    decoded_immediate = 8'h11; upd(1'b1, 4'd12, M_CONST, 4'b1111, 4'd0);
    decoded_immediate = 8'h33; upd(1'b0, 4'd3, M_CONST, 4'b0000, 4'd0);
    req(1'b0, 4'd3, 4'd9);
    req(1'b1, 4'd12, 4'd12);
    n_cmp++; if ({rs, v_rs} !== {8'h33, 32'h11111111}) begin n_err++; $display("FAIL pre_reset_values: got %h expected 3311111111", {rs, v_rs}); end
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if ({clear_busy, read_valid} !== 2'b00) begin n_err++; $display("FAIL async_reset_flags: got %b expected 00", {clear_busy, read_valid}); end
    n_cmp++; if ({rs, rt, v_rs, v_rt} !== 80'h0) begin n_err++; $display("FAIL async_reset_outputs: got %h expected 0", {rs, rt, v_rs, v_rt}); end
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (clear_busy !== 1'b0) begin n_err++; $display("FAIL busy_after_release: got %b expected 0", clear_busy); end
    req(1'b0, 4'd3, 4'd9);
    n_cmp++; if ({rs, rt} !== 16'h0) begin n_err++; $display("FAIL scalar_cleared: got %h expected 0000", {rs, rt}); end
    req(1'b1, 4'd12, 4'd7);
    n_cmp++; if ({v_rs, v_rt} !== 64'h0) begin n_err++; $display("FAIL vector_cleared: got %h expected 0", {v_rs, v_rt}); end
  endtask

  initial begin
    test_reset();
    test_ro_regs();
    test_scalar_write();
    test_vector_write();
    test_clear_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
